// File: rtl/tx_block_drain_pkg.sv
// Shared crypto-datapath definitions used by the transmit drain.
package tx_block_drain_pkg;

  localparam int BLOCK_W = 64;
  localparam int BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    LOAD = 2'd2,
    SEND = 2'd3
  } tx_drain_state_t;

endpackage

// File: rtl/tx_block_drain_serializer.sv
// Shift register plus byte index: loads a block, presents its MSB byte and
// shifts one byte per accepted transfer.
module block_serializer #(
  parameter int DATA_W = 64,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              clr,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              last
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;

  // clr only rewinds the index; the stale shift contents are never shown
  // because the next block always passes through a load first.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      shreg <= '0;
      idx   <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (load) begin
      shreg <= din;
      idx   <= '0;
    end else if (shift) begin
      shreg <= shreg << BYTE_W;
      idx   <= idx + IDX_W'(1);
    end
  end

  assign dout = shreg[DATA_W-1 -: BYTE_W];
  assign last = (idx == IDX_LAST);

endmodule

// File: rtl/tx_block_drain.sv
// Transmit drain: pops 64-bit blocks from the Tx FIFO and streams them MSB
// byte first over a valid/ready byte interface, counting completed blocks.
module tx_block_drain #(
  parameter int DATA_W = 64,
  parameter int BYTE_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              emptyTx,
  input  logic [DATA_W-1:0] tx_rdata,
  output logic              tx_deq,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_byte,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  blk_count
);

  import tx_block_drain_pkg::*;

  tx_drain_state_t   state;
  tx_drain_state_t   state_nxt;
  logic              ser_last;
  logic [BYTE_W-1:0] ser_byte;
  logic              hs;
  logic              blk_done;

  assign hs       = (state == SEND) && out_ready;
  assign blk_done = hs && ser_last;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!emptyTx) state_nxt = POP;
      POP:     state_nxt = LOAD;
      LOAD:    state_nxt = SEND;
      SEND:    if (blk_done) state_nxt = emptyTx ? IDLE : POP;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // A block whose final byte is accepted still counts even if flush hits
  // in the same cycle.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state     <= IDLE;
      blk_count <= '0;
    end else begin
      state <= state_nxt;
      if (blk_done) blk_count <= blk_count + CNT_W'(1);
    end
  end

  block_serializer #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W)
  ) u_ser (
    .clk     (clk),
    .n_reset (n_reset),
    .clr     (flush),
    .load    (state == LOAD),
    .shift   (hs),
    .din     (tx_rdata),
    .dout    (ser_byte),
    .last    (ser_last)
  );

  assign tx_deq    = (state == POP);
  assign out_valid = (state == SEND);
  assign out_last  = out_valid && ser_last;
  assign out_byte  = out_valid ? ser_byte : '0;
  assign busy      = (state != IDLE);

endmodule
